// File: rtl/id_imm_stage.sv
// ---------------------------------------------------------------------------
// id_imm_stage
//
// IF->ID pipeline stage that feeds the immediate extender. Fetched
// instructions arrive over a valid/ready handshake and are kept in a
// two-entry skid buffer (main entry + skid entry). Each instruction's opcode
// is pre-decoded into a 3-bit immediate-select code and an illegal flag when
// it is written into the buffer. All outputs come straight from the main
// entry's flops, so downstream decode sees registered, stable inputs.
//
// Parameters:
//   PC_W          width of the program-counter field carried with each beat
//
// Ports:
//   clk           clock, rising edge
//   rst_n         asynchronous active-low reset
//   flush         synchronous kill of all buffered entries (redirect)
//   in_valid      fetch presents an instruction
//   in_ready      stage can accept this cycle (skid entry is free)
//   in_instr      fetched instruction word
//   in_pc         PC of in_instr
//   out_valid     head (main) entry valid
//   out_ready     downstream consumes the head entry this cycle
//   out_instr     head instruction
//   out_pc        head PC
//   out_imm_sel   immediate select for the extender
//   out_imm_data  instr[31:7] of the head entry
//   out_illegal   head opcode is not recognised
// ---------------------------------------------------------------------------
module id_imm_stage #(
    parameter int PC_W = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [PC_W-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_instr,
    output logic [PC_W-1:0] out_pc,
    output logic [2:0]      out_imm_sel,
    output logic [24:0]     out_imm_data,
    output logic            out_illegal
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b10
    } state_e;

    // Immediate-select codes understood by the extender.
    localparam logic [2:0] SEL_I     = 3'b000;
    localparam logic [2:0] SEL_S     = 3'b001;
    localparam logic [2:0] SEL_B     = 3'b010;
    localparam logic [2:0] SEL_SHIFT = 3'b011;
    localparam logic [2:0] SEL_J     = 3'b100;
    localparam logic [2:0] SEL_U     = 3'b101;
    localparam logic [2:0] SEL_BAD   = 3'b111;

    // Returns {illegal, imm_sel}. Opcodes whose low two bits are not 2'b11
    // never match a case item, so they land in the illegal default.
    function automatic logic [3:0] decode_imm(input logic [31:0] instr);
        logic [3:0] res;
        res = {1'b1, SEL_BAD};
        case (instr[6:0])
            7'b0000011,                                    // load
            7'b1100111,                                    // JALR
            7'b1110011: res = {1'b0, SEL_I};               // SYSTEM
            7'b0010011: begin                              // OP-IMM
                if ((instr[14:12] == 3'b001) || (instr[14:12] == 3'b101)) begin
                    res = {1'b0, SEL_SHIFT};
                end else begin
                    res = {1'b0, SEL_I};
                end
            end
            7'b0100011: res = {1'b0, SEL_S};               // store
            7'b1100011: res = {1'b0, SEL_B};               // branch
            7'b1101111: res = {1'b0, SEL_J};               // JAL
            7'b0110111,                                    // LUI
            7'b0010111: res = {1'b0, SEL_U};               // AUIPC
            7'b0110011,                                    // R-type
            7'b0001111: res = {1'b0, SEL_I};               // FENCE
            default:    res = {1'b1, SEL_BAD};
        endcase
        return res;
    endfunction

    state_e          state_q, state_d;
    logic            main_valid_q, skid_valid_q;
    logic [31:0]     main_instr_q, main_instr_d;
    logic [PC_W-1:0] main_pc_q, main_pc_d;
    logic [2:0]      main_sel_q, main_sel_d;
    logic            main_ill_q, main_ill_d;
    logic [31:0]     skid_instr_q, skid_instr_d;
    logic [PC_W-1:0] skid_pc_q, skid_pc_d;
    logic [2:0]      skid_sel_q, skid_sel_d;
    logic            skid_ill_q, skid_ill_d;

    logic            accept_s, pop_s;
    logic            load_main_in_s, load_main_skid_s, load_skid_s;
    logic [3:0]      in_dec_s;

    assign in_ready     = ~skid_valid_q;
    assign out_valid    = main_valid_q;
    assign out_instr    = main_instr_q;
    assign out_pc       = main_pc_q;
    assign out_imm_sel  = main_sel_q;
    assign out_imm_data = main_instr_q[31:7];
    assign out_illegal  = main_ill_q;

    assign accept_s = in_valid & ~skid_valid_q;
    assign pop_s    = main_valid_q & out_ready;
    assign in_dec_s = decode_imm(in_instr);

    // Next-state and buffer-write control; flush overrides every transition.
    always_comb begin
        state_d          = state_q;
        load_main_in_s   = 1'b0;
        load_main_skid_s = 1'b0;
        load_skid_s      = 1'b0;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept_s) begin
                        state_d        = ST_ONE;
                        load_main_in_s = 1'b1;
                    end else begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (accept_s && pop_s) begin
                        state_d        = ST_ONE;
                        load_main_in_s = 1'b1;
                    end else if (accept_s) begin
                        state_d     = ST_FULL;
                        load_skid_s = 1'b1;
                    end else if (pop_s) begin
                        state_d = ST_EMPTY;
                    end else begin
                        state_d = ST_ONE;
                    end
                end
                ST_FULL: begin
                    // in_ready is low here, so only a pop can move us.
                    if (pop_s) begin
                        state_d          = ST_ONE;
                        load_main_skid_s = 1'b1;
                    end else begin
                        state_d = ST_FULL;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    // Data path of both entries: main takes the new beat or the skid beat.
    always_comb begin
        main_instr_d = main_instr_q;
        main_pc_d    = main_pc_q;
        main_sel_d   = main_sel_q;
        main_ill_d   = main_ill_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        skid_sel_d   = skid_sel_q;
        skid_ill_d   = skid_ill_q;
        if (load_main_in_s) begin
            main_instr_d = in_instr;
            main_pc_d    = in_pc;
            main_sel_d   = in_dec_s[2:0];
            main_ill_d   = in_dec_s[3];
        end else if (load_main_skid_s) begin
            main_instr_d = skid_instr_q;
            main_pc_d    = skid_pc_q;
            main_sel_d   = skid_sel_q;
            main_ill_d   = skid_ill_q;
        end else begin
            main_instr_d = main_instr_q;
        end
        if (load_skid_s) begin
            skid_instr_d = in_instr;
            skid_pc_d    = in_pc;
            skid_sel_d   = in_dec_s[2:0];
            skid_ill_d   = in_dec_s[3];
        end else if (load_main_skid_s) begin
            skid_instr_d = 32'h0000_0000;
            skid_pc_d    = {PC_W{1'b0}};
            skid_sel_d   = 3'b000;
            skid_ill_d   = 1'b0;
        end else begin
            skid_instr_d = skid_instr_q;
        end
    end

    // State, valid bits and entry storage; valid bits track the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_EMPTY;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            main_instr_q <= 32'h0000_0000;
            main_pc_q    <= {PC_W{1'b0}};
            main_sel_q   <= 3'b000;
            main_ill_q   <= 1'b0;
            skid_instr_q <= 32'h0000_0000;
            skid_pc_q    <= {PC_W{1'b0}};
            skid_sel_q   <= 3'b000;
            skid_ill_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            main_valid_q <= (state_d != ST_EMPTY);
            skid_valid_q <= (state_d == ST_FULL);
            main_instr_q <= main_instr_d;
            main_pc_q    <= main_pc_d;
            main_sel_q   <= main_sel_d;
            main_ill_q   <= main_ill_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
            skid_sel_q   <= skid_sel_d;
            skid_ill_q   <= skid_ill_d;
        end
    end

endmodule

// File: tb/tb_id_imm_stage.sv
module tb_id_imm_stage;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [2:0]  out_imm_sel;
    logic [24:0] out_imm_data;
    logic        out_illegal;

    int n_checks;
    int n_fail;

    id_imm_stage #(.PC_W(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_instr     (in_instr),
        .in_pc        (in_pc),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_instr    (out_instr),
        .out_pc       (out_pc),
        .out_imm_sel  (out_imm_sel),
        .out_imm_data (out_imm_data),
        .out_illegal  (out_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // advance one rising edge and settle a little after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = 32'h0; in_pc = 32'h0; out_ready = 1'b0;
        #12;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %0b exp 0", out_valid); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %0b exp 1", in_ready); end
        n_checks++; if (out_instr !== 32'h0) begin n_fail++; $display("FAIL reset_out_instr got %h exp 0", out_instr); end
        n_checks++; if (out_imm_sel !== 3'b000) begin n_fail++; $display("FAIL reset_imm_sel got %b exp 000", out_imm_sel); end
        n_checks++; if (out_illegal !== 1'b0) begin n_fail++; $display("FAIL reset_illegal got %b exp 0", out_illegal); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_addi();
        @(negedge clk);
        in_valid = 1'b1; in_instr = 32'h00500093; in_pc = 32'h100; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL addi_valid got %b exp 1", out_valid); end
        n_checks++; if (out_imm_sel !== 3'b000) begin n_fail++; $display("FAIL addi_sel got %b exp 000", out_imm_sel); end
        n_checks++; if (out_imm_data !== 25'h00A001) begin n_fail++; $display("FAIL addi_data got %h exp 00a001", out_imm_data); end
        n_checks++; if (out_pc !== 32'h100) begin n_fail++; $display("FAIL addi_pc got %h exp 100", out_pc); end
        n_checks++; if (out_illegal !== 1'b0) begin n_fail++; $display("FAIL addi_illegal got %b exp 0", out_illegal); end
        step();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL addi_drain got %b exp 0", out_valid); end
    endtask

    task automatic test_stream();
        logic [31:0] instrs [5];
        logic [2:0]  sels   [5];
        instrs[0] = 32'h00112623; sels[0] = 3'b001;
        instrs[1] = 32'h00208463; sels[1] = 3'b010;
        instrs[2] = 32'h008000EF; sels[2] = 3'b100;
        instrs[3] = 32'h123452B7; sels[3] = 3'b101;
        instrs[4] = 32'h00209093; sels[4] = 3'b011;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_instr = instrs[i]; in_pc = 32'h200 + 32'(i * 4);
            step();
            n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stream_valid[%0d] got %b exp 1", i, out_valid); end
            n_checks++; if (out_imm_sel !== sels[i]) begin n_fail++; $display("FAIL stream_sel[%0d] got %b exp %b", i, out_imm_sel, sels[i]); end
            n_checks++; if (out_instr !== instrs[i]) begin n_fail++; $display("FAIL stream_instr[%0d] got %h exp %h", i, out_instr, instrs[i]); end
            n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_ready[%0d] got %b exp 1", i, in_ready); end
        end
        in_valid = 1'b0;
        step();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_drain got %b exp 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'h00100113; in_pc = 32'h300;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready0 got %b exp 1", in_ready); end
        step();
        in_instr = 32'h00200193; in_pc = 32'h304;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready1 got %b exp 1", in_ready); end
        step();
        in_instr = 32'h00300213; in_pc = 32'h308;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready2 got %b exp 0", in_ready); end
        n_checks++; if (out_instr !== 32'h00100113) begin n_fail++; $display("FAIL bp_hold1 got %h exp 00100113", out_instr); end
        step();
        n_checks++; if (out_instr !== 32'h00100113) begin n_fail++; $display("FAIL bp_hold2 got %h exp 00100113", out_instr); end
        n_checks++; if (out_pc !== 32'h300) begin n_fail++; $display("FAIL bp_hold_pc got %h exp 300", out_pc); end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready3 got %b exp 0", in_ready); end
        in_valid = 1'b0; out_ready = 1'b1;
        step();
        n_checks++; if (out_instr !== 32'h00200193) begin n_fail++; $display("FAIL bp_second got %h exp 00200193", out_instr); end
        n_checks++; if (out_pc !== 32'h304) begin n_fail++; $display("FAIL bp_second_pc got %h exp 304", out_pc); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_back got %b exp 1", in_ready); end
        step();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain got %b exp 0", out_valid); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'h00100113; in_pc = 32'h400;
        step();
        in_instr = 32'h00200193; in_pc = 32'h404;
        step();
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_full got %b exp 0", in_ready); end
        flush = 1'b1; in_instr = 32'h00300213; in_pc = 32'h408;
        step();
        flush = 1'b0; in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid got %b exp 0", out_valid); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_ready got %b exp 1", in_ready); end
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_ghost[%0d] got %b exp 0", i, out_valid); end
        end
    endtask

    task automatic test_illegal();
        out_ready = 1'b1;
        in_valid = 1'b1; in_instr = 32'h00000000; in_pc = 32'h500;
        step();
        n_checks++; if (out_illegal !== 1'b1) begin n_fail++; $display("FAIL zero_illegal got %b exp 1", out_illegal); end
        n_checks++; if (out_imm_sel !== 3'b111) begin n_fail++; $display("FAIL zero_sel got %b exp 111", out_imm_sel); end
        in_instr = 32'h0000000F; in_pc = 32'h504;
        step();
        n_checks++; if (out_illegal !== 1'b0) begin n_fail++; $display("FAIL fence_illegal got %b exp 0", out_illegal); end
        n_checks++; if (out_imm_sel !== 3'b000) begin n_fail++; $display("FAIL fence_sel got %b exp 000", out_imm_sel); end
        in_instr = 32'h00000073; in_pc = 32'h508;
        step();
        n_checks++; if ({out_illegal, out_imm_sel} !== 4'b0000) begin n_fail++; $display("FAIL system_dec got %b exp 0000", {out_illegal, out_imm_sel}); end
        in_instr = 32'hFFFFF017; in_pc = 32'h50C;
        step();
        n_checks++; if ({out_illegal, out_imm_sel} !== 4'b0101) begin n_fail++; $display("FAIL auipc_dec got %b exp 0101", {out_illegal, out_imm_sel}); end
        n_checks++; if (out_imm_data !== 25'h1FFFFE0) begin n_fail++; $display("FAIL auipc_data got %h exp 1ffffe0", out_imm_data); end
        in_instr = 32'h00000012; in_pc = 32'h510;
        step();
        n_checks++; if ({out_illegal, out_imm_sel} !== 4'b1111) begin n_fail++; $display("FAIL compressed_dec got %b exp 1111", {out_illegal, out_imm_sel}); end
        in_valid = 1'b0;
        step();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ill_drain got %b exp 0", out_valid); end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'h00112623; in_pc = 32'h600;
        step();
        in_instr = 32'h00208463; in_pc = 32'h604;
        step();
        in_valid = 1'b0;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL ar_full got %b exp 0", in_ready); end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ar_valid got %b exp 0", out_valid); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL ar_ready got %b exp 1", in_ready); end
        n_checks++; if (out_instr !== 32'h0) begin n_fail++; $display("FAIL ar_instr got %h exp 0", out_instr); end
        n_checks++; if (out_pc !== 32'h0) begin n_fail++; $display("FAIL ar_pc got %h exp 0", out_pc); end
        n_checks++; if (out_imm_data !== 25'h0) begin n_fail++; $display("FAIL ar_data got %h exp 0", out_imm_data); end
        n_checks++; if ({out_illegal, out_imm_sel} !== 4'b0000) begin n_fail++; $display("FAIL ar_dec got %b exp 0000", {out_illegal, out_imm_sel}); end
        step();
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL ar_held_ready got %b exp 1", in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        step();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ar_after got %b exp 0", out_valid); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_addi();
        test_stream();
        test_back_to_back();
        test_flush();
        test_illegal();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
